// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN image path: frame geometry,
// pixel/address widths and the image loader state encoding.
package cnn_pkg;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int NUM_PIX = IMG_W * IMG_H;
    localparam int PIX_W   = 8;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/image_loader.sv
// Stream-to-RAM writer: accepts one framed pixel stream and writes it in
// raster order through a registered write port, reporting completion/errors.
module image_loader #(
    parameter int PIX_W   = cnn_pkg::PIX_W,
    parameter int NUM_PIX = cnn_pkg::NUM_PIX,
    parameter int ADDR_W  = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_valid,
    output logic              err,
    output logic [ADDR_W-1:0] pix_count
);

    import cnn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pix_count_q, pix_count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_q, err_d;

    logic accepting;
    logic xfer;

    assign accepting = (state_q == FILL) || (state_q == DRAIN);
    assign xfer      = s_valid && accepting;

    // Abort has priority over everything, including a same-cycle start or pixel.
    always_comb begin
        state_d       = state_q;
        pix_count_d   = pix_count_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = 1'b0;
        frame_valid_d = frame_valid_q;
        err_d         = err_q;

        if (abort) begin
            if (state_q != IDLE) begin
                state_d       = IDLE;
                frame_valid_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d       = FILL;
                        pix_count_d   = '0;
                        err_d         = 1'b0;
                        frame_valid_d = 1'b0;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = pix_count_q;
                        mem_wdata_d = s_data;
                        pix_count_d = pix_count_q + ADDR_W'(1);
                        if (pix_count_q == LAST_ADDR) begin
                            if (s_last) begin
                                state_d       = DONE;
                                done_d        = 1'b1;
                                frame_valid_d = 1'b1;
                            end else begin
                                state_d = DRAIN;
                            end
                        end else if (s_last) begin
                            state_d       = DONE;
                            done_d        = 1'b1;
                            err_d         = 1'b1;
                            frame_valid_d = 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Overflow pixels are swallowed until the frame marker arrives.
                    if (xfer && s_last) begin
                        state_d       = DONE;
                        done_d        = 1'b1;
                        err_d         = 1'b1;
                        frame_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pix_count_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            done_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_count_q   <= pix_count_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    assign s_ready     = accepting;
    assign busy        = accepting;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign done        = done_q;
    assign frame_valid = frame_valid_q;
    assign err         = err_q;
    assign pix_count   = pix_count_q;

endmodule

// File: tb/tb_image_loader.sv
// Randomized scoreboard bench for image_loader: a frame-level model queues the
// expected writes/done pulses and a negedge monitor compares what the DUT emits.
module tb_image_loader;

    localparam int NUM = 784;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       frame_valid;
    logic       err;
    logic [9:0] pix_count;

    image_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .frame_valid(frame_valid), .err(err),
        .pix_count(pix_count)
    );

    typedef struct {
        bit we;
        int addr;
        int data;
        bit dn;
        bit fv;
        bit er;
        int cyc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   cyc     = 0;

    // Frame-level model: phase 0 idle, 1 loading, 2 finished.
    int mPhase = 0;
    int mIndex = 0;
    bit mFv    = 0;
    bit mErr   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (mem_we || done)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", {30'd0, mem_we, done}, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("mon.we", int'(mem_we), int'(e.we));
                checkOutput("mon.done", int'(done), int'(e.dn));
                checkOutput("mon.cycle", cyc, e.cyc);
                if (e.we) begin
                    checkOutput("mon.addr", int'(mem_addr), e.addr);
                    checkOutput("mon.data", int'(mem_wdata), e.data);
                end
                if (e.dn) begin
                    checkOutput("mon.frame_valid", int'(frame_valid), int'(e.fv));
                    checkOutput("mon.err", int'(err), int'(e.er));
                end
            end
        end
    end

    task automatic modelPixel(input int d, input bit l);
        int k;
        k = mIndex;
        if (k < NUM) begin
            expQ.push_back('{we: 1'b1, addr: k, data: d & 255, dn: l,
                             fv: (l && k == NUM - 1), er: (l && k != NUM - 1), cyc: cyc + 1});
        end else if (l) begin
            expQ.push_back('{we: 1'b0, addr: 0, data: 0, dn: 1'b1, fv: 1'b0, er: 1'b1, cyc: cyc + 1});
        end
        if (l) begin
            mPhase = 2;
            mFv    = (k == NUM - 1);
            mErr   = (k != NUM - 1);
        end
        mIndex++;
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit l, input bit st, input bit ab);
        s_valid = v;
        s_data  = v ? d[7:0] : 8'($urandom);
        s_last  = v ? l : 1'($urandom);
        start   = st;
        abort   = ab;
        if (ab) begin
            if (mPhase != 0) begin
                mPhase = 0;
                mFv    = 0;
            end
        end else if (v && mPhase == 1) begin
            modelPixel(d, l);
        end else if (st && mPhase != 1) begin
            mPhase = 1;
            mIndex = 0;
            mErr   = 0;
            mFv    = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    // gapMode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random gaps.
    task automatic sendFrame(input int n, input int lastAt, input int gapMode,
                             input bit addrData, input int startAt);
        int sent;
        int slot;
        bit v;
        sent = 0;
        slot = 0;
        while (sent < n) begin
            case (gapMode)
                0:       v = 1'b1;
                1:       v = (slot % 4 == 0) || (slot % 4 == 3);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (v) begin
                applyStimulus(1, addrData ? sent : int'($urandom), sent == lastAt, sent == startAt, 0);
                sent++;
            end else begin
                applyStimulus(0, 0, 0, 0, 0);
            end
            slot++;
        end
    endtask

    task automatic checkStatus(input string name);
        checkOutput({name, ".frame_valid"}, int'(frame_valid), int'(mFv));
        checkOutput({name, ".err"}, int'(err), int'(mErr));
        checkOutput({name, ".pix_count"}, int'(pix_count), (mIndex > NUM) ? NUM : mIndex);
        checkOutput({name, ".busy"}, int'(busy), int'(mPhase == 1));
        checkOutput({name, ".s_ready"}, int'(s_ready), int'(mPhase == 1));
    endtask

    task automatic checkDrained(input string name);
        idle(3);
        checkOutput({name, ".pending"}, expQ.size(), 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".s_ready"}, int'(s_ready), 0);
        checkOutput({name, ".mem_we"}, int'(mem_we), 0);
        checkOutput({name, ".mem_addr"}, int'(mem_addr), 0);
        checkOutput({name, ".mem_wdata"}, int'(mem_wdata), 0);
        checkOutput({name, ".busy"}, int'(busy), 0);
        checkOutput({name, ".done"}, int'(done), 0);
        checkOutput({name, ".frame_valid"}, int'(frame_valid), 0);
        checkOutput({name, ".err"}, int'(err), 0);
        checkOutput({name, ".pix_count"}, int'(pix_count), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
        #2;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        $display("[TB] nominal frame");
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(NUM, NUM - 1, 0, 1, -1);
        checkDrained("nominal");
        checkStatus("nominal");

        $display("[TB] gapped frame");
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(NUM, NUM - 1, 1, 0, -1);
        checkDrained("gapped");
        checkStatus("gapped");

        $display("[TB] short frame, pixels ignored while DONE");
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(101, 100, 2, 0, -1);
        for (int i = 0; i < 5; i++) applyStimulus(1, int'($urandom), 1'($urandom), 0, 0);
        checkDrained("short");
        checkStatus("short");

        $display("[TB] restart clears err, then abort at pixel 300");
        applyStimulus(0, 0, 0, 1, 0);
        checkStatus("restart");
        sendFrame(300, -1, 2, 0, -1);
        applyStimulus(0, 0, 0, 0, 1);
        checkStatus("abort");
        checkDrained("abort");
        checkStatus("abort_idle");

        $display("[TB] long frame");
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(790, 789, 2, 0, -1);
        checkDrained("long");
        checkStatus("long");

        $display("[TB] start with abort while DONE");
        applyStimulus(0, 0, 0, 1, 1);
        checkStatus("start_abort");
        idle(2);

        $display("[TB] reset at pixel 300");
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(300, -1, 2, 0, -1);
        idle(2);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        expQ.delete();
        mPhase = 0; mIndex = 0; mFv = 0; mErr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        $display("[TB] clean frame with start during FILL");
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(NUM, NUM - 1, 2, 0, 400);
        checkDrained("clean");
        checkStatus("clean");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Stream-to-RAM writer that fills the 784-entry, 8-bit image memory consumed by the CNN datapath. It is the producer side of the memory interface.
- Accepts one frame of 8-bit pixels over a valid/ready stream with an end-of-frame marker. Drives a single registered write port (we/addr/data) in raster order.
- Reports frame completion and framing errors so the convolution control can start reading.

Parameters:
- PIX_W, 8, pixel width in bits
- NUM_PIX, 784, pixels per frame (28x28)
- ADDR_W, 10, write address width; must satisfy 2^ADDR_W >= NUM_PIX

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin loading a frame
- abort  in  1  synchronous abort of the current load
- s_valid  in  1  input pixel valid
- s_data  in  PIX_W  input pixel, two's-complement byte
- s_last  in  1  marks final pixel of frame; qualified by s_valid
- s_ready  out  1  loader accepts a pixel this cycle
- mem_we  out  1  write enable to image memory
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  PIX_W  write data
- busy  out  1  state is FILL or DRAIN
- done  out  1  one-cycle pulse at end of frame, good or bad
- frame_valid  out  1  memory holds a complete, correctly framed image
- err  out  1  sticky framing error for the last frame
- pix_count  out  ADDR_W  pixels written in the current frame

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0: s_ready, mem_we, mem_addr, mem_wdata, busy, done, frame_valid, err, pix_count.
- Handshake: a pixel transfers on any cycle with s_valid && s_ready. s_ready is a Moore output: 1 in FILL and DRAIN, 0 otherwise. The upstream may insert gaps, and s_data is ignored when not transferred.
- States:
  - IDLE: start -> FILL; clears pix_count, err and frame_valid.
  - FILL: each transfer registers mem_we=1, mem_addr=pix_count, mem_wdata=s_data on the next edge, then pix_count++. Latency is exactly 1 cycle from handshake to write. mem_we=0 on cycles without a transfer.
    - Transfer with s_last=1 at pix_count==NUM_PIX-1: the pixel is written; done=1 and frame_valid=1 in the same cycle as that write. Next state DONE.
    - Transfer with s_last=1 at pix_count<NUM_PIX-1 (short frame): the pixel is written; err=1, done=1, frame_valid=0. Next state DONE.
    - Transfer with s_last=0 at pix_count==NUM_PIX-1 (long frame): the pixel is written. Next state DRAIN.
  - DRAIN: pixels are accepted and discarded, with no mem_we and pix_count held at NUM_PIX. A transfer with s_last=1 gives err=1, done=1, frame_valid=0, next state DONE.
  - DONE: s_ready=0. frame_valid and err hold. start -> FILL and clears them.
- start while busy is ignored.
- abort in FILL, DRAIN or DONE -> IDLE next cycle. It clears frame_valid; err and pix_count keep their values; no done pulse. mem_we is 0 from the cycle after abort. abort and start in the same cycle: abort wins.
- Address never exceeds NUM_PIX-1, and there is no wrap-around write.
- Reset mid-frame: immediate return to the reset values above. The partial frame is not reported.

Decomposition:
- Shared cnn_pkg holds:
  - IMG_W=28, IMG_H=28, NUM_PIX=784, PIX_W=8, ADDR_W=10
  - state encoding localparams: IDLE, FILL, DRAIN, DONE
- No sub-module is needed: a single FSM plus the pix_count counter.
- The memory stays a separate block; a top wrapper ties mem_we/mem_addr/mem_wdata to its write port.

Test Plan:
- Nominal frame: start, then 784 back-to-back pixels with data=addr[7:0] and s_last on #783 -> 784 writes at addr 0..783, each 1 cycle after its handshake; done pulses once with the write to 783; frame_valid=1, err=0, pix_count=784.
- Backpressure/gaps: s_valid toggling 1,0,0,1 pattern over a full frame -> writes only on transfer cycles, addresses contiguous 0..783, same final status as nominal.
- Short frame: s_last on pixel #100 -> writes addr 0..100, done pulse, err=1, frame_valid=0; the next start clears err.
- Long frame: 790 pixels, s_last on #789 -> writes 0..783 only; no mem_we for pixels 784..789; done on the #789 handshake+1, err=1.
- Abort/reset mid-fill: abort at pixel 300 -> IDLE, s_ready=0, no done, frame_valid=0. Repeat with rst at pixel 300 -> all outputs 0 asynchronously. Then a fresh start produces a clean nominal frame.
- start+abort same cycle in DONE -> IDLE. start during FILL -> ignored, pix_count continues.
